// File: rtl/tester_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default requester count and transaction timeout.
package tester_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_N_REQ       = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first unmasked request at or above
// ptr, wrapping past the top requester back to zero.
module rr_picker
    import tester_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [1:0]       ptr,
    output logic             valid,
    output logic [1:0]       idx
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] eff;

    assign eff = req & ~mask;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid && eff[IW'((32'(ptr) + i) % N_REQ)]) begin
                valid = 1'b1;
                idx   = 2'((32'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters,
// with an optional grant-to-completion timeout.
module uart_tx_arbiter
    import tester_pkg::*;
#(
    parameter int unsigned N_REQ       = DEF_N_REQ,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     done,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [1:0]           grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam bit              TO_EN    = (TIMEOUT_CYC > 0);
    localparam int unsigned     CW       = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0]   CNT_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [CW-1:0]    cnt;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [7:0]       pick_byte;
    logic [N_REQ-1:0] grant_onehot;
    logic [1:0]       next_ptr;
    logic             timeout_hit;

    // The registered done pulse doubles as the mask, so a request still held
    // during its own done cycle cannot be granted again immediately.
    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .mask  (done),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_byte    = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(pick_idx) == i) pick_byte = req_data[8*i +: 8];
            grant_onehot[i] = (32'(grant_id) == i);
        end
    end

    assign next_ptr    = (32'(grant_id) == N_REQ - 1) ? 2'd0 : grant_id + 2'd1;
    assign timeout_hit = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            done        <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= WAIT_RDY;
                        grant_id <= pick_idx;
                        tx_data  <= pick_byte;
                        cnt      <= '0;
                        active   <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    // Timeout wins over a start in the same cycle: the byte is abandoned.
                    if (timeout_hit) begin
                        state       <= IDLE;
                        active      <= 1'b0;
                        done        <= grant_onehot;
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                    end else begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            state    <= WAIT_DONE;
                        end
                        if (TO_EN) cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state  <= IDLE;
                        active <= 1'b0;
                        done   <= grant_onehot;
                        rr_ptr <= next_ptr;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        active      <= 1'b0;
                        done        <= grant_onehot;
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                    end else if (TO_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a cycle-by-cycle vector table for arbitration, masking and
// reset, plus hand sequences for busy-wait and the timeout paths.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] req_data = {8'h5A, 8'h3C, 8'hA5};
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [2:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic [2:0]  req2 = '0;
    logic        tx_busy2 = 1'b0;
    logic        tx_done2 = 1'b0;
    logic [2:0]  done2;
    logic        tx_start2;
    logic [7:0]  tx_data2;
    logic [1:0]  grant_id2;
    logic        active2;
    logic        timeout_err2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(3), .TIMEOUT_CYC(100000)) dut (
        .in_clk(clk), .in_rst(rst_n), .req(req), .req_data(req_data),
        .done(done), .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start),
        .tx_data(tx_data), .grant_id(grant_id), .active(active),
        .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.N_REQ(3), .TIMEOUT_CYC(16)) dut_to (
        .in_clk(clk), .in_rst(rst_n), .req(req2), .req_data(req_data),
        .done(done2), .tx_busy(tx_busy2), .tx_done(tx_done2), .tx_start(tx_start2),
        .tx_data(tx_data2), .grant_id(grant_id2), .active(active2),
        .timeout_err(timeout_err2)
    );

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       busy;
        logic       tdone;
        logic       s;
        logic [2:0] d;
        logic [1:0] g;
        logic       a;
        logic       e;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [2:0] r, input logic b, input logic t,
                       input logic s, input logic [2:0] d, input logic [1:0] g,
                       input logic a, input logic e, input logic [7:0] data);
        vec_t v;
        v.rst = rst; v.req = r; v.busy = b; v.tdone = t;
        v.s = s; v.d = d; v.g = g; v.a = a; v.e = e; v.data = data;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int starts;
        logic [15:0] exp_v;
        logic [15:0] got_v;

        //    rst req    bsy tdn  s  done   gid  act err data
        add(0, 3'b000, 0, 0,   0, 3'b000, 2'd0, 0, 0, 8'h00);
        add(1, 3'b001, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 1,   1, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 1,   0, 3'b001, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b000, 0, 1,   0, 3'b000, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   1, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 1,   0, 3'b001, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   0, 3'b000, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b001, 0, 0,   1, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(0, 3'b001, 0, 1,   0, 3'b000, 2'd0, 0, 0, 8'h00);
        add(1, 3'b110, 0, 0,   0, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b110, 0, 0,   1, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b110, 0, 1,   0, 3'b010, 2'd1, 0, 0, 8'h3C);
        add(0, 3'b000, 0, 0,   0, 3'b000, 2'd0, 0, 0, 8'h00);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 0,   1, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 1,   0, 3'b001, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b111, 0, 0,   1, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b111, 0, 1,   0, 3'b010, 2'd1, 0, 0, 8'h3C);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd2, 1, 0, 8'h5A);
        add(1, 3'b111, 0, 0,   1, 3'b000, 2'd2, 1, 0, 8'h5A);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd2, 1, 0, 8'h5A);
        add(1, 3'b111, 0, 1,   0, 3'b100, 2'd2, 0, 0, 8'h5A);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 0,   1, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 0,   0, 3'b000, 2'd0, 1, 0, 8'hA5);
        add(1, 3'b111, 0, 1,   0, 3'b001, 2'd0, 0, 0, 8'hA5);
        add(1, 3'b011, 0, 0,   0, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b011, 0, 0,   1, 3'b000, 2'd1, 1, 0, 8'h3C);
        add(1, 3'b011, 0, 1,   0, 3'b010, 2'd1, 0, 0, 8'h3C);
        add(1, 3'b000, 0, 0,   0, 3'b000, 2'd1, 0, 0, 8'h3C);

        foreach (tbl[i]) begin
            rst_n   = tbl[i].rst;
            req     = tbl[i].req;
            tx_busy = tbl[i].busy;
            tx_done = tbl[i].tdone;
            step();
            exp_v = {tbl[i].s, tbl[i].d, tbl[i].g, tbl[i].a, tbl[i].e, tbl[i].data};
            got_v = {tx_start, done, grant_id, active, timeout_err, tx_data};
            check($sformatf("vec%0d", i), 32'(got_v), 32'(exp_v));
        end
        tx_done = 1'b0;

        // Busy wait: requester 2 granted while the transmitter stays busy.
        req = 3'b100;
        tx_busy = 1'b1;
        step();
        check("busy_grant", {21'd0, active, grant_id, tx_data}, {21'd0, 1'b1, 2'd2, 8'h5A});
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("busy_hold%0d", k), {30'd0, tx_start, active}, {30'd0, 1'b0, 1'b1});
        end
        tx_busy = 1'b0;
        step();
        check("busy_start", 32'(tx_start), 32'd1);
        step();
        check("busy_start_1cyc", 32'(tx_start), 32'd0);
        tx_done = 1'b1;
        step();
        check("busy_done", {28'd0, done, active}, {28'd0, 3'b100, 1'b0});
        tx_done = 1'b0;
        req = 3'b000;
        step();
        check("busy_done_1cyc", 32'(done), 32'd0);

        // Timeout after start, never completed.
        req2 = 3'b001;
        step();
        check("to_grant", {22'd0, active2, grant_id2, tx_data2}, {22'd0, 1'b1, 2'd0, 8'hA5});
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) check("to_start", 32'(tx_start2), 32'd1);
            if (k < 16)
                check($sformatf("to_wait%0d", k), {27'd0, timeout_err2, done2, active2}, {27'd0, 1'b0, 3'b000, 1'b1});
            else
                check("to_fire", {27'd0, timeout_err2, done2, active2}, {27'd0, 1'b1, 3'b001, 1'b0});
        end
        req2 = 3'b000;
        step();
        check("to_fire_1cyc", {28'd0, timeout_err2, done2}, 32'd0);

        // Timeout while still waiting for the transmitter: no start at all.
        req2 = 3'b010;
        tx_busy2 = 1'b1;
        step();
        check("to2_grant", {29'd0, active2, grant_id2}, {29'd0, 1'b1, 2'd1});
        starts = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            starts += int'(tx_start2);
            if (k == 16)
                check("to2_fire", {27'd0, timeout_err2, done2, active2}, {27'd0, 1'b1, 3'b010, 1'b0});
        end
        check("to2_no_start", starts, 32'd0);
        req2 = 3'b000;
        tx_busy2 = 1'b0;
        step();

        // tx_done in the same cycle as the timeout counts as normal completion.
        req2 = 3'b100;
        step();
        check("to3_grant", {29'd0, active2, grant_id2}, {29'd0, 1'b1, 2'd2});
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) tx_done2 = 1'b1;
            step();
            if (k == 16)
                check("to3_done", {27'd0, timeout_err2, done2, active2}, {27'd0, 1'b0, 3'b100, 1'b0});
        end
        tx_done2 = 1'b0;
        req2 = 3'b000;
        step();
        check("to3_after", {28'd0, timeout_err2, done2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, 3, number of requesters sharing the UART transmitter (fixed range 2..4).
REQ-002 Parameter TIMEOUT_CYC, 100000, max cycles from grant to tx_done; 0 disables the timeout.
REQ-003 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-004 in_clk  input  1  system clock, all logic on rising edge.
REQ-005 in_rst  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester send request, level, held until its done pulse.
REQ-007 req_data  input  8*N_REQ  packed bytes; requester i occupies bits [8i+7:8i], stable while req[i] high.
REQ-008 done  output  N_REQ  one-cycle pulse to the served requester when its byte is finished or aborted.
REQ-009 tx_busy  input  1  transmitter busy flag.
REQ-010 tx_done  input  1  one-cycle transmitter completion pulse.
REQ-011 tx_start  output  1  one-cycle transmit start pulse.
REQ-012 tx_data  output  8  byte for the transmitter, valid from tx_start until return to IDLE.
REQ-013 grant_id  output  2  index of the current/last granted requester.
REQ-014 active  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-016 States SHALL be IDLE, WAIT_RDY, WAIT_DONE; all outputs registered.
REQ-017 IDLE: if any unmasked req bit is high, the arbiter SHALL pick the first set bit searching from rr_ptr upward with wrap, latch its byte into tx_data and its index into grant_id, and go to WAIT_RDY.
REQ-018 WAIT_RDY: when tx_busy is low, the arbiter SHALL drive tx_start high for exactly one cycle and go to WAIT_DONE; while tx_busy is high it SHALL wait.
REQ-019 WAIT_DONE: on tx_done, the arbiter SHALL pulse done[grant_id] for one cycle, set rr_ptr to (grant_id+1) mod N_REQ, and return to IDLE.
REQ-020 Latency: with tx_busy low, tx_start SHALL be high during the cycle after the second rising edge following the first IDLE edge that samples req; done SHALL follow tx_done by one edge.
REQ-021 tx_done in IDLE or WAIT_RDY SHALL be ignored.
REQ-022 In the IDLE cycle in which done[i] is high, req[i] SHALL be masked so that a still-high request is not re-granted.
REQ-023 A req bit dropped after grant SHALL NOT cancel the transaction; tx_start and done still occur.
REQ-024 Timeout counter SHALL clear on grant and count in WAIT_RDY and WAIT_DONE; on reaching TIMEOUT_CYC-1 the arbiter SHALL pulse timeout_err and done[grant_id] in the same cycle, advance rr_ptr, and return to IDLE without tx_start if not yet issued.
REQ-025 Counter width SHALL be clog2(TIMEOUT_CYC+1); no wrap is permitted.
REQ-026 Simultaneous tx_done and timeout SHALL be treated as normal completion without timeout_err.

Reset
REQ-027 While in_rst is low, the block SHALL set state IDLE, rr_ptr 0, counter 0, tx_start 0, tx_data 0x00, done 0, grant_id 0, active 0, and timeout_err 0.
REQ-028 A reset mid-transaction SHALL abandon it with no done pulse; after release, arbitration SHALL restart from requester 0.

Structure
REQ-029 Shared package tester_pkg SHALL hold the state enum, the default N_REQ, and the default TIMEOUT_CYC.
REQ-030 Round-robin selection SHALL be a separate combinational sub-module rr_picker taking inputs req, mask, and ptr, and producing outputs valid and idx.

Verification
REQ-031 Single request: req=001, data0=0xA5, tx_busy=0 -> tx_start for 1 cycle at edge+2, tx_data=0xA5; tx_done -> done=001 next cycle.
REQ-032 Fairness: req=111 held, each transaction completed -> grant order 0,1,2,0, with done pulses matching.
REQ-033 Busy wait: tx_busy=1 for 20 cycles after grant -> no tx_start until the cycle after tx_busy falls.
REQ-034 Timeout: TIMEOUT_CYC=16, tx_done never arrives -> timeout_err and done[grant] pulse together 16 cycles after grant, IDLE.
REQ-035 Re-grant mask: req0 kept high through done, req1 high -> next grant is 1, not 0.
REQ-036 Reset: in_rst low during WAIT_DONE -> all outputs reset immediately, no done; after release, req=110 grants 1.
